// File: rtl/wb_cmd_master.sv
// Wishbone B4 classic-cycle command master: executes single or multi-beat read/write commands, one response per beat.
// Define WB_CMD_MASTER_BURST_EN to issue multi-beat commands as incrementing bursts (cti 010/111, cyc held between beats).
module wb_cmd_master #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int LENW      = 8,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3
) (
    input  logic            clk_i,
    input  logic            nrst_i,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    input  logic [DW/8-1:0] cmd_sel,
    input  logic [LENW-1:0] cmd_len,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic [1:0]      rsp_status,
    output logic            rsp_last,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic            wbm_we_o,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic [2:0]      wbm_cti_o,
    output logic [1:0]      wbm_bte_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i,
    input  logic            wbm_err_i,
    input  logic            wbm_rty_i
);

    localparam int SW = DW / 8;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_RTY = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

`ifdef WB_CMD_MASTER_BURST_EN
    localparam logic       BURST    = 1'b1;
    localparam logic [2:0] CTI_MID  = 3'b010;
    localparam logic [2:0] CTI_LAST = 3'b111;
`else
    localparam logic       BURST    = 1'b0;
    localparam logic [2:0] CTI_MID  = 3'b000;
    localparam logic [2:0] CTI_LAST = 3'b000;
`endif

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        BACKOFF,
        RSP
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [LENW-1:0] beat_cnt;
    logic [RW-1:0]   retry_cnt;
    logic [TW-1:0]   tmo_cnt;

    logic            cmd_fire;
    logic            retry_ok;
    logic            tmo_hit;
    logic            more_beats;
    logic            keep_cyc;
    logic [AW-1:0]   adr_nx;

    function automatic logic [2:0] cti_for(input logic last_beat);
        return last_beat ? CTI_LAST : CTI_MID;
    endfunction

    assign wbm_bte_o = 2'b00;

    always_comb begin
        cmd_fire   = cmd_valid && cmd_ready;
        retry_ok   = (retry_cnt < RETRY_MAX);
        tmo_hit    = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
        more_beats = (rsp_status == ST_OK) && (beat_cnt != '0);
        // In burst mode an acked beat with beats left keeps the cycle open through RSP.
        keep_cyc   = BURST && (beat_cnt != '0);
        adr_nx     = wbm_adr_o + AW'(SW);
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    state_nx = BUS;
                end
            end
            BUS: begin
                if (wbm_err_i || wbm_ack_i) begin
                    state_nx = RSP;
                end else if (wbm_rty_i) begin
                    state_nx = retry_ok ? BACKOFF : RSP;
                end else if (tmo_hit) begin
                    state_nx = RSP;
                end
            end
            BACKOFF: begin
                state_nx = BUS;
            end
            RSP: begin
                if (rsp_ready) begin
                    state_nx = more_beats ? BUS : IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_dat    <= '0;
            rsp_status <= ST_OK;
            rsp_last   <= 1'b0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
            wbm_sel_o  <= '0;
            wbm_we_o   <= 1'b0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_cti_o  <= 3'b000;
            beat_cnt   <= '0;
            retry_cnt  <= '0;
            tmo_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_fire) begin
                        cmd_ready <= 1'b0;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                        wbm_sel_o <= cmd_sel;
                        wbm_we_o  <= cmd_we;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_cti_o <= cti_for(cmd_len == '0);
                        beat_cnt  <= cmd_len;
                        retry_cnt <= '0;
                        tmo_cnt   <= '0;
                    end
                end
                BUS: begin
                    if (wbm_err_i) begin
                        wbm_cyc_o  <= 1'b0;
                        wbm_stb_o  <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_dat    <= '0;
                        rsp_status <= ST_ERR;
                        rsp_last   <= 1'b1;
                    end else if (wbm_ack_i) begin
                        wbm_cyc_o  <= keep_cyc;
                        wbm_stb_o  <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_dat    <= wbm_we_o ? '0 : wbm_dat_i;
                        rsp_status <= ST_OK;
                        rsp_last   <= (beat_cnt == '0);
                    end else if (wbm_rty_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        if (retry_ok) begin
                            retry_cnt <= retry_cnt + 1'b1;
                        end else begin
                            rsp_valid  <= 1'b1;
                            rsp_dat    <= '0;
                            rsp_status <= ST_RTY;
                            rsp_last   <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        wbm_cyc_o  <= 1'b0;
                        wbm_stb_o  <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_dat    <= '0;
                        rsp_status <= ST_TMO;
                        rsp_last   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                BACKOFF: begin
                    // Reissue the same beat after one idle bus cycle.
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    tmo_cnt   <= '0;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (more_beats) begin
                            wbm_adr_o <= adr_nx;
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_cti_o <= cti_for(beat_cnt == LENW'(1));
                            beat_cnt  <= beat_cnt - LENW'(1);
                            retry_cnt <= '0;
                            tmo_cnt   <= '0;
                        end else begin
                            wbm_cyc_o <= 1'b0;
                            cmd_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: vector table of plain commands plus hand sequences for retry, timeout, err, backpressure and reset.
module tb_wb_cmd_master;

    localparam int K_ACK    = 0;
    localparam int K_ERR    = 1;
    localparam int K_RTY    = 2;
    localparam int K_SIL    = 3;
    localparam int K_ERRACK = 4;
    localparam int NV       = 4;
    localparam int LOGN     = 128;

    logic        clk = 1'b0;
    logic        nrst_i;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic [7:0]  cmd_len;
    logic        rsp_valid, rsp_ready, rsp_last;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i, wbm_err_i, wbm_rty_i;

    always #5 clk = ~clk;

    wb_cmd_master dut (
        .clk_i(clk), .nrst_i(nrst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_status(rsp_status), .rsp_last(rsp_last),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Slave script, written by the main thread only; scr_gen bump restarts the slave.
    int          scr_kind [16];
    int          scr_dly  [16];
    logic [31:0] scr_dat  [16];
    int          scr_gen = 0;

    int          seen_gen = 0;
    int          sidx = 0;
    int          wcnt = 0;
    int          bus_n = 0;
    int          stb_cyc = 0;
    logic [31:0] b_adr [LOGN];
    logic [31:0] b_dat [LOGN];
    logic [3:0]  b_sel [LOGN];
    logic        b_we  [LOGN];
    logic [2:0]  b_cti [LOGN];

    always @(negedge clk) begin
        if (seen_gen != scr_gen) begin
            seen_gen = scr_gen;
            sidx = 0;
            wcnt = 0;
        end
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_rty_i = 1'b0;
        wbm_dat_i = 32'h0;
        if (wbm_cyc_o && wbm_stb_o) begin
            stb_cyc++;
            if (sidx < 16 && scr_kind[sidx] != K_SIL && wcnt >= scr_dly[sidx]) begin
                case (scr_kind[sidx])
                    K_ERR:    wbm_err_i = 1'b1;
                    K_RTY:    wbm_rty_i = 1'b1;
                    K_ERRACK: begin wbm_err_i = 1'b1; wbm_ack_i = 1'b1; end
                    default:  wbm_ack_i = 1'b1;
                endcase
                wbm_dat_i = scr_dat[sidx];
                if (bus_n < LOGN) begin
                    b_adr[bus_n] = wbm_adr_o;
                    b_dat[bus_n] = wbm_dat_o;
                    b_sel[bus_n] = wbm_sel_o;
                    b_we[bus_n]  = wbm_we_o;
                    b_cti[bus_n] = wbm_cti_o;
                end
                bus_n++;
                sidx++;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end
    end

    int          rsp_n = 0;
    logic [31:0] r_dat  [LOGN];
    logic [1:0]  r_st   [LOGN];
    logic        r_last [LOGN];

    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (rsp_n < LOGN) begin
                r_dat[rsp_n]  = rsp_dat;
                r_st[rsp_n]   = rsp_status;
                r_last[rsp_n] = rsp_last;
            end
            rsp_n++;
        end
    end

    task automatic load_script(input int kind, input int dly, input logic [31:0] rbase);
        for (int k = 0; k < 16; k++) begin
            scr_kind[k] = kind;
            scr_dly[k]  = dly;
            scr_dat[k]  = rbase * (k + 1);
        end
    endtask

    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic [7:0] len);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_len   = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int n;
        n = 0;
        while (rsp_n < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("rsp_count", rsp_n, target);
    endtask

    function automatic logic [2:0] exp_cti(input int len, input int k);
`ifdef WB_CMD_MASTER_BURST_EN
        return (k == len) ? 3'b111 : 3'b010;
`else
        return (len >= 0 && k >= 0) ? 3'b000 : 3'b000;
`endif
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [7:0]  len;
        int          dly;
        logic [31:0] rbase;
        int          exp_beats;
        logic [31:0] exp_last_adr;
        logic [31:0] exp_first_rdat;
    } vec_t;

    vec_t vecs [NV];

    initial begin
        int b0, r0, s0, n, stable;
        logic [31:0] hd;
        logic [1:0]  hs;
        logic        hl;

        vecs[0] = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 8'd0, 2, 32'h5A5A_5A5A, 1, 32'h0000_0100, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 8'd3, 0, 32'h0000_0011, 4, 32'h0000_001C, 32'h11};
        vecs[2] = '{1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 4'h3, 8'd1, 1, 32'h0,         2, 32'h0000_0000, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0200, 32'h0,         4'h1, 8'd0, 3, 32'hCAFE_F00D, 1, 32'h0000_0200, 32'hCAFE_F00D};

        nrst_i = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; cmd_len = '0; rsp_ready = 1'b1;
        load_script(K_ACK, 0, 32'h0);

        repeat (3) @(posedge clk); #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_dat", rsp_dat, 32'h0);
        check("rst_rsp_status", 32'(rsp_status), 32'd0);
        check("rst_cyc_stb", 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
        check("rst_wbm_adr", wbm_adr_o, 32'h0);
        check("rst_bte", 32'(wbm_bte_o), 32'd0);
        nrst_i = 1'b1;
        @(posedge clk); #1;
        check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        for (int v = 0; v < NV; v++) begin
            load_script(K_ACK, vecs[v].dly, vecs[v].rbase);
            scr_gen++;
            b0 = bus_n;
            r0 = rsp_n;
            send_cmd(vecs[v].we, vecs[v].adr, vecs[v].dat, vecs[v].sel, vecs[v].len);
            wait_rsp(r0 + vecs[v].exp_beats, 200);
            check($sformatf("v%0d_bus_beats", v), bus_n - b0, vecs[v].exp_beats);
            for (int k = 0; k < vecs[v].exp_beats; k++) begin
                check($sformatf("v%0d_b%0d_adr", v, k), b_adr[b0 + k], vecs[v].adr + 32'(4 * k));
                check($sformatf("v%0d_b%0d_we", v, k), 32'(b_we[b0 + k]), 32'(vecs[v].we));
                check($sformatf("v%0d_b%0d_sel", v, k), 32'(b_sel[b0 + k]), 32'(vecs[v].sel));
                check($sformatf("v%0d_b%0d_cti", v, k), 32'(b_cti[b0 + k]), 32'(exp_cti(vecs[v].len, k)));
                if (vecs[v].we)
                    check($sformatf("v%0d_b%0d_wdat", v, k), b_dat[b0 + k], vecs[v].dat);
                check($sformatf("v%0d_r%0d_dat", v, k), r_dat[r0 + k],
                      vecs[v].we ? 32'h0 : vecs[v].rbase * (k + 1));
                check($sformatf("v%0d_r%0d_status", v, k), 32'(r_st[r0 + k]), 32'd0);
                check($sformatf("v%0d_r%0d_last", v, k), 32'(r_last[r0 + k]),
                      32'(k == vecs[v].exp_beats - 1));
            end
            check($sformatf("v%0d_first_rdat", v), r_dat[r0], vecs[v].exp_first_rdat);
            check($sformatf("v%0d_last_adr", v), b_adr[b0 + vecs[v].exp_beats - 1], vecs[v].exp_last_adr);
        end

        // Three retries then ack: succeeds on the fourth attempt.
        load_script(K_ACK, 0, 32'h0);
        scr_kind[0] = K_RTY; scr_kind[1] = K_RTY; scr_kind[2] = K_RTY;
        scr_dat[3] = 32'h0BAD_CAFE;
        scr_gen++;
        b0 = bus_n; r0 = rsp_n;
        send_cmd(1'b0, 32'h40, 32'h0, 4'hF, 8'd0);
        wait_rsp(r0 + 1, 200);
        check("rty3_attempts", bus_n - b0, 4);
        check("rty3_reissue_adr", b_adr[b0 + 3], 32'h40);
        check("rty3_status", 32'(r_st[r0]), 32'd0);
        check("rty3_last", 32'(r_last[r0]), 32'd1);
        check("rty3_rdat", r_dat[r0], 32'h0BAD_CAFE);

        // Four retries: exhausted.
        load_script(K_RTY, 0, 32'h0);
        scr_gen++;
        b0 = bus_n; r0 = rsp_n;
        send_cmd(1'b0, 32'h44, 32'h0, 4'hF, 8'd0);
        wait_rsp(r0 + 1, 200);
        check("rty4_attempts", bus_n - b0, 4);
        check("rty4_status", 32'(r_st[r0]), 32'd2);
        check("rty4_last", 32'(r_last[r0]), 32'd1);

        // Silent slave: strobe held exactly TIMEOUT cycles.
        load_script(K_SIL, 0, 32'h0);
        scr_gen++;
        b0 = bus_n; r0 = rsp_n; s0 = stb_cyc;
        send_cmd(1'b1, 32'h80, 32'h1, 4'hF, 8'd0);
        wait_rsp(r0 + 1, 400);
        check("tmo_stb_cycles", stb_cyc - s0, 255);
        check("tmo_status", 32'(r_st[r0]), 32'd3);
        check("tmo_last", 32'(r_last[r0]), 32'd1);
        check("tmo_cyc_low", 32'(wbm_cyc_o), 32'd0);

        // err+ack together on beat 2 of 4: err wins, rest aborted.
        load_script(K_ACK, 0, 32'h0000_0101);
        scr_kind[1] = K_ERRACK; scr_dly[1] = 1;
        scr_gen++;
        b0 = bus_n; r0 = rsp_n; s0 = stb_cyc;
        send_cmd(1'b0, 32'h300, 32'h0, 4'hF, 8'd3);
        wait_rsp(r0 + 2, 200);
        repeat (10) @(posedge clk); #1;
        check("err_rsp_total", rsp_n - r0, 2);
        check("err_bus_beats", bus_n - b0, 2);
        check("err_stb_cycles", stb_cyc - s0, 3);
        check("err_b1_status", 32'(r_st[r0]), 32'd0);
        check("err_b1_last", 32'(r_last[r0]), 32'd0);
        check("err_b2_status", 32'(r_st[r0 + 1]), 32'd1);
        check("err_b2_last", 32'(r_last[r0 + 1]), 32'd1);
        check("err_cyc_low", 32'(wbm_cyc_o), 32'd0);

        // Backpressure on beat 1: response held stable, no strobe.
        load_script(K_ACK, 0, 32'h0000_00A1);
        scr_dat[1] = 32'h0000_00B2;
        scr_gen++;
        rsp_ready = 1'b0;
        b0 = bus_n; r0 = rsp_n;
        send_cmd(1'b0, 32'h500, 32'h0, 4'hF, 8'd1);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        hd = rsp_dat; hs = rsp_status; hl = rsp_last;
        s0 = stb_cyc;
        stable = 1;
        repeat (10) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_dat !== hd || rsp_status !== hs ||
                rsp_last !== hl || wbm_stb_o !== 1'b0)
                stable = 0;
        end
        check("bp_hold_stable", stable, 1);
        check("bp_no_stb", stb_cyc - s0, 0);
        check("bp_held_dat", hd, 32'h0000_00A1);
        check("bp_held_last", 32'(hl), 32'd0);
        rsp_ready = 1'b1;
        wait_rsp(r0 + 2, 100);
        check("bp_b2_dat", r_dat[r0 + 1], 32'h0000_00B2);
        check("bp_b2_last", 32'(r_last[r0 + 1]), 32'd1);
        check("bp_bus_beats", bus_n - b0, 2);

        // Reset pulsed mid-bus-cycle.
        load_script(K_SIL, 0, 32'h0);
        scr_gen++;
        r0 = rsp_n;
        send_cmd(1'b1, 32'h600, 32'h77, 4'hF, 8'd0);
        repeat (3) @(posedge clk); #1;
        check("mid_rst_cyc_before", 32'(wbm_cyc_o), 32'd1);
        #2 nrst_i = 1'b0;
        #1;
        check("mid_rst_cyc_stb", 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #2;
        nrst_i = 1'b1;
        #1;
        check("rel_cmd_ready_before_edge", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("rel_cmd_ready_after_edge", 32'(cmd_ready), 32'd1);
        repeat (5) @(posedge clk); #1;
        check("mid_rst_no_rsp", rsp_n - r0, 0);

        // Recovery after the reset.
        load_script(K_ACK, 1, 32'h0);
        scr_gen++;
        r0 = rsp_n;
        send_cmd(1'b1, 32'h700, 32'h99, 4'hF, 8'd0);
        wait_rsp(r0 + 1, 100);
        check("recover_status", 32'(r_st[r0]), 32'd0);
        check("recover_last", 32'(r_last[r0]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
